// File: rtl/calc_pkg.sv
// Shared calculator definitions: entry FSM states, key code type and
// keypad geometry. Imported by the keypad scanner and the entry FSM.
package calc_pkg;

    localparam int KEY_ROWS = 4;
    localparam int KEY_COLS = 4;

    typedef logic [3:0] key_code_t;

    typedef enum logic [1:0] {
        GET_A  = 2'd0,
        GET_B  = 2'd1,
        GET_OP = 2'd2,
        SHOW   = 2'd3
    } entry_state_t;

    // Key code is 4*row + col, i.e. {row, col} for a 4x4 pad.
    function automatic key_code_t key_index(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce.
//   clock, reset : system clock, asynchronous active-high reset
//   row_n        : raw keypad rows (active-low), synchronized internally
//   col_n        : column drive, exactly one bit low
//   key_event    : one-cycle pulse when a single key becomes stably pressed
//   key_code     : code of the stable key (valid with key_event)
module keypad_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [KEY_ROWS-1:0] row_n,
    output logic [KEY_COLS-1:0] col_n,
    output logic                key_event,
    output key_code_t           key_code
);

    localparam int DWELL_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int MATCH_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [MATCH_W-1:0] MATCH_FULL = MATCH_W'(DEBOUNCE_SCANS);

    logic [KEY_ROWS-1:0] row_sync1_reg, row_sync2_reg;
    logic [DWELL_W-1:0]  dwell_reg;
    logic [1:0]          col_idx_reg;
    // Hits accumulated over the columns already sampled in this scan:
    // 0, 1, or 2 meaning "two or more".
    logic [1:0]          acc_hits_reg;
    key_code_t           acc_code_reg;
    logic                prev_pressed_reg, prev_multi_reg;
    key_code_t           prev_code_reg;
    logic [MATCH_W-1:0]  match_cnt_reg;
    logic                stable_pressed_reg, stable_multi_reg;
    key_code_t           stable_code_reg;
    logic                key_event_reg;

    logic [KEY_ROWS-1:0] row_low;
    logic [1:0]          col_hits, scan_hits;
    logic [1:0]          col_row;
    logic [2:0]          hit_sum;
    logic                scan_pressed, scan_multi, last_dwell;
    key_code_t           scan_code, acc_code_next;
    logic                scan_match;
    logic [MATCH_W-1:0]  match_next;

    for (genvar gi = 0; gi < KEY_ROWS; gi++) begin : g_row_low
        assign row_low[gi] = ~row_sync2_reg[gi];
    end

    assign col_n      = ~(KEY_COLS'(1) << col_idx_reg);
    assign last_dwell = (dwell_reg == DWELL_LAST);
    assign key_event  = key_event_reg;
    assign key_code   = stable_code_reg;

    // Hits in the column currently driven, plus the first low row index.
    always_comb begin
        col_hits = 2'd0;
        col_row  = 2'd0;
        for (int r = 0; r < KEY_ROWS; r++) begin
            if (row_low[r]) begin
                if (col_hits == 2'd0) col_row = 2'(r);
                col_hits = (col_hits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    // Scan result as it would stand if this column closed the scan.
    always_comb begin
        hit_sum       = {1'b0, acc_hits_reg} + {1'b0, col_hits};
        scan_hits     = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_pressed  = (scan_hits == 2'd1);
        scan_multi    = (scan_hits == 2'd2);
        scan_code     = '0;
        if (scan_pressed)
            scan_code = (acc_hits_reg == 2'd1) ? acc_code_reg : key_index(col_row, col_idx_reg);
        acc_code_next = (acc_hits_reg == 2'd0 && col_hits == 2'd1)
                        ? key_index(col_row, col_idx_reg) : acc_code_reg;
        // The multi-key flag takes part in the comparison so a ghost pattern
        // must itself be stable before it replaces the stable state.
        scan_match    = (scan_pressed == prev_pressed_reg) && (scan_multi == prev_multi_reg)
                        && (scan_code == prev_code_reg);
        match_next    = MATCH_W'(1);
        if (scan_match)
            match_next = (match_cnt_reg == MATCH_FULL) ? MATCH_FULL : match_cnt_reg + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_sync1_reg      <= '1;
            row_sync2_reg      <= '1;
            dwell_reg          <= '0;
            col_idx_reg        <= 2'd0;
            acc_hits_reg       <= 2'd0;
            acc_code_reg       <= '0;
            prev_pressed_reg   <= 1'b0;
            prev_multi_reg     <= 1'b0;
            prev_code_reg      <= '0;
            match_cnt_reg      <= '0;
            stable_pressed_reg <= 1'b0;
            stable_multi_reg   <= 1'b0;
            stable_code_reg    <= '0;
            key_event_reg      <= 1'b0;
        end else begin
            row_sync1_reg <= row_n;
            row_sync2_reg <= row_sync1_reg;
            key_event_reg <= 1'b0;
            if (last_dwell) begin
                dwell_reg   <= '0;
                col_idx_reg <= col_idx_reg + 2'd1;
                if (col_idx_reg == 2'd3) begin
                    acc_hits_reg     <= 2'd0;
                    acc_code_reg     <= '0;
                    prev_pressed_reg <= scan_pressed;
                    prev_multi_reg   <= scan_multi;
                    prev_code_reg    <= scan_code;
                    match_cnt_reg    <= match_next;
                    if (match_next == MATCH_FULL) begin
                        stable_pressed_reg <= scan_pressed;
                        stable_multi_reg   <= scan_multi;
                        stable_code_reg    <= scan_code;
                        // Only a clean release (no keys at all) arms the next
                        // event; leaving a ghost pattern or sliding from one
                        // key to another never fires.
                        key_event_reg <= scan_pressed && !stable_pressed_reg && !stable_multi_reg;
                    end
                end else begin
                    acc_hits_reg <= scan_hits;
                    acc_code_reg <= acc_code_next;
                end
            end else begin
                dwell_reg <= dwell_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry front end for the calculator: scans the keypad and assembles
// operand A, operand B and the opcode from successive key presses.
//   clock, reset   : system clock, asynchronous active-high reset
//   clear          : asynchronous abort level, synchronized internally
//   row_n / col_n  : keypad matrix (active-low)
//   A, B, Opcode   : captured entry
//   entry_state    : GET_A / GET_B / GET_OP / SHOW
//   operands_valid : high while A/B/Opcode form a complete entry
//   go             : one-cycle pulse when an entry completes
module keypad_entry
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [3:0] Opcode,
    output logic [1:0] entry_state,
    output logic       operands_valid,
    output logic       go
);

    logic         key_event;
    key_code_t    key_code;
    logic         clear_sync1_reg, clear_sync2_reg;
    entry_state_t state_reg;
    key_code_t    a_reg, b_reg, op_reg;
    logic         valid_reg, go_reg;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clock     (clock),
        .reset     (reset),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_event (key_event),
        .key_code  (key_code)
    );

    assign A              = a_reg;
    assign B              = b_reg;
    assign Opcode         = op_reg;
    assign entry_state    = state_reg;
    assign operands_valid = valid_reg;
    assign go             = go_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clear_sync1_reg <= 1'b0;
            clear_sync2_reg <= 1'b0;
        end else begin
            clear_sync1_reg <= clear;
            clear_sync2_reg <= clear_sync1_reg;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= GET_A;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            valid_reg <= 1'b0;
            go_reg    <= 1'b0;
        end else begin
            go_reg <= 1'b0;
            if (clear_sync2_reg) begin
                // Clear wins; a key_event arriving now is discarded.
                state_reg <= GET_A;
                a_reg     <= '0;
                b_reg     <= '0;
                op_reg    <= '0;
                valid_reg <= 1'b0;
            end else if (key_event) begin
                case (state_reg)
                    GET_A: begin
                        a_reg     <= key_code;
                        state_reg <= GET_B;
                    end
                    GET_B: begin
                        b_reg     <= key_code;
                        state_reg <= GET_OP;
                    end
                    GET_OP: begin
                        op_reg    <= key_code;
                        valid_reg <= 1'b1;
                        go_reg    <= 1'b1;
                        state_reg <= SHOW;
                    end
                    SHOW: begin
                        // First key of a new entry; B and Opcode keep old values.
                        a_reg     <= key_code;
                        valid_reg <= 1'b0;
                        state_reg <= GET_B;
                    end
                    default: state_reg <= GET_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
module tb_keypad_entry;

    localparam int SD = 4;
    localparam int DS = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       clear = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n, A, B, Opcode;
    logic [1:0] entry_state;
    logic       operands_valid, go;
    logic [15:0] keys = '0;

    keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
        .clock          (clock),
        .reset          (reset),
        .clear          (clear),
        .row_n          (row_n),
        .col_n          (col_n),
        .A              (A),
        .B              (B),
        .Opcode         (Opcode),
        .entry_state    (entry_state),
        .operands_valid (operands_valid),
        .go             (go)
    );

    always #5 clock = ~clock;

    // Keypad: a pressed key at (r,c) pulls row r low while column c is driven.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
        logic       valid;
        logic       go;
    } snap_t;

    typedef struct {
        snap_t s;
        int    t0;
        int    lo;
        int    hi;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, go_seen = 0, go_exp = 0;

    // Reference model of the entry sequence.
    int         m_st = 0;
    logic [3:0] m_a = '0, m_b = '0, m_op = '0;
    logic       m_valid = 1'b0;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    function automatic snap_t model_snap(input logic g);
        snap_t s;
        s.st = 2'(m_st); s.a = m_a; s.b = m_b; s.op = m_op; s.valid = m_valid; s.go = g;
        return s;
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.st = entry_state; s.a = A; s.b = B; s.op = Opcode; s.valid = operands_valid; s.go = go;
        return s;
    endfunction

    task automatic push_exp(input logic g, input int lo, input int hi);
        exp_t e;
        e.s = model_snap(g); e.t0 = cyc; e.lo = lo; e.hi = hi;
        exp_q.push_back(e);
        if (g) go_exp++;
    endtask

    task automatic model_key(input int code, input int lo, input int hi);
        logic g;
        g = 1'b0;
        case (m_st)
            0: begin m_a = 4'(code); m_st = 1; end
            1: begin m_b = 4'(code); m_st = 2; end
            2: begin m_op = 4'(code); m_valid = 1'b1; g = 1'b1; m_st = 3; end
            default: begin m_a = 4'(code); m_valid = 1'b0; m_st = 1; end
        endcase
        push_exp(g, lo, hi);
    endtask

    task automatic model_clear();
        snap_t old_s;
        old_s = model_snap(1'b0);
        m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0;
        if (model_snap(1'b0) != old_s) push_exp(1'b0, 3, 3);
    endtask

    task automatic check_val(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic check_model(input string name);
        snap_t d, m;
        d = dut_snap();
        m = model_snap(1'b0);
        checks++;
        if (d !== m) begin
            errors++;
            $display("FAIL %s got st=%0d A=%0d B=%0d Op=%0d v=%0d go=%0d expected st=%0d A=%0d B=%0d Op=%0d v=%0d go=0",
                     name, d.st, d.a, d.b, d.op, d.valid, d.go, m.st, m.a, m.b, m.op, m.valid);
        end
        check_val({name, "_pending"}, exp_q.size(), 0);
    endtask

    // Monitor: every change of the visible entry registers pops one expectation.
    initial begin
        snap_t prev_s, cur_s;
        exp_t  e;
        int    lat;
        prev_s = '0;
        forever begin
            @(negedge clock);
            cur_s = dut_snap();
            if (reset) begin
                prev_s = cur_s;
            end else begin
                if (go) go_seen++;
                if (cur_s[15:1] != prev_s[15:1]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_update got st=%0d A=%0d B=%0d Op=%0d v=%0d go=%0d expected no change",
                                 cur_s.st, cur_s.a, cur_s.b, cur_s.op, cur_s.valid, cur_s.go);
                    end else begin
                        e = exp_q.pop_front();
                        lat = cyc - e.t0;
                        $display("txn cyc=%0d st=%0d A=%0d B=%0d Op=%0d v=%0d go=%0d lat=%0d",
                                 cyc, cur_s.st, cur_s.a, cur_s.b, cur_s.op, cur_s.valid, cur_s.go, lat);
                        if (cur_s !== e.s) begin
                            errors++;
                            $display("FAIL entry_update got st=%0d A=%0d B=%0d Op=%0d v=%0d go=%0d expected st=%0d A=%0d B=%0d Op=%0d v=%0d go=%0d",
                                     cur_s.st, cur_s.a, cur_s.b, cur_s.op, cur_s.valid, cur_s.go,
                                     e.s.st, e.s.a, e.s.b, e.s.op, e.s.valid, e.s.go);
                        end
                        checks++;
                        if (lat < e.lo || lat > e.hi) begin
                            errors++;
                            $display("FAIL latency got %0d expected %0d..%0d", lat, e.lo, e.hi);
                        end
                    end
                end else if (go) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_go got go=1 expected go=0 without an entry update");
                end
                prev_s = cur_s;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Clean press of one key, optionally preceded by contact bounce.
    task automatic press_key(input int code, input int bounce, input int hold, input int rel);
        int elapsed, d;
        model_key(code, (bounce > 0) ? 0 : 18, bounce + 6 + 52);
        elapsed = 0;
        while (elapsed < bounce) begin
            keys[code] = ~keys[code];
            d = $urandom_range(1, 6);
            tick(d);
            elapsed += d;
        end
        keys[code] = 1'b1;
        tick(hold);
        keys[code] = 1'b0;
        tick(rel);
    endtask

    task automatic ghost(input int k1, input int k2, input bit rel_first_k2);
        keys[k1] = 1'b1;
        keys[k2] = 1'b1;
        tick(100);
        check_model("ghost_both");
        if (rel_first_k2) keys[k2] = 1'b0; else keys[k1] = 1'b0;
        tick(100);
        check_model("ghost_one_left");
        keys = '0;
        tick(80);
        check_model("ghost_released");
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        model_clear();
        tick(10);
        clear = 1'b0;
        tick(6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k1, k2;
        // Reset values.
        tick(3);
        check_val("rst_col_n", col_n, 4'b1110);
        check_model("rst_outputs");

        // Column sequence from deassertion: 1110,1101,1011,0111 every 4 cycles.
        @(negedge clock);
        #1 reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            check_val("col_seq", col_n, 4'(~(4'b0001 << ((k / 4) % 4))));
        end
        tick(40);
        check_model("idle_no_key");

        // Entry sequence 3, 5, 9.
        press_key(3, 0, 70, 70);
        press_key(5, 0, 70, 70);
        press_key(9, 0, 70, 70);
        check_model("entry_359");
        check_val("entry_go_count", go_seen, 1);

        // Re-entry from SHOW.
        press_key(12, 0, 70, 70);
        check_model("reentry_12");

        // Clear held across a key_event in GET_OP.
        press_key(2, 0, 70, 70);
        clear = 1'b1;
        model_clear();
        tick(8);
        keys[4] = 1'b1;
        tick(80);
        keys[4] = 1'b0;
        tick(80);
        check_model("clear_in_get_op");
        clear = 1'b0;
        tick(6);

        // Clear in SHOW: operands_valid drops on the third edge.
        press_key(3, 0, 70, 70);
        press_key(5, 0, 70, 70);
        press_key(9, 0, 70, 70);
        check_val("show_valid", operands_valid, 1);
        clear = 1'b1;
        model_clear();
        tick(1);
        check_val("clr_edge1_valid", operands_valid, 1);
        tick(1);
        check_val("clr_edge2_valid", operands_valid, 1);
        tick(1);
        check_val("clr_edge3_valid", operands_valid, 0);
        clear = 1'b0;
        tick(6);

        // Bounce then hold key 7: one event only.
        model_key(7, 0, 40 + 52);
        for (int i = 0; i < 8; i++) begin
            keys[7] = ~keys[7];
            tick(5);
        end
        keys[7] = 1'b1;
        tick(200);
        check_model("bounce_hold_7");
        keys[7] = 1'b0;
        tick(70);

        // Ghosting: 1 and 6 together, then 6 released first.
        ghost(1, 6, 1'b1);

        // Randomized mix of presses, ghost patterns and clears.
        for (int n = 0; n < 30; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 70) begin
                press_key($urandom_range(0, 15), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 24) : 0,
                          $urandom_range(64, 120), $urandom_range(64, 120));
            end else if (r < 85) begin
                k1 = $urandom_range(0, 15);
                k2 = (k1 + $urandom_range(1, 15)) % 16;
                ghost(k1, k2, $urandom_range(0, 1) == 1);
            end else begin
                clear_pulse();
            end
        end
        check_model("random_mix");

        // Reset in the middle of an entry.
        press_key(10, 0, 70, 70);
        press_key(11, 0, 70, 7);
        #2 reset = 1'b1;
        #1;
        check_val("midrst_col_n", col_n, 4'b1110);
        m_st = 0; m_a = '0; m_b = '0; m_op = '0; m_valid = 1'b0;
        check_model("midrst_outputs");
        tick(5);
        reset = 1'b0;
        tick(2);
        press_key(13, 0, 70, 70);
        check_model("after_midrst");

        tick(100);
        check_val("go_total", go_seen, go_exp);
        check_model("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
